// File: rtl/spu_pkg.sv
// Shared SPU widths, format codes and even-pipe shift/rotate opcodes.
package spu_pkg;
  localparam int NUM_REGS = 128;
  localparam int REG_W    = 128;
  localparam int CNT_W    = 3;
  localparam int OP_W     = 11;
  localparam int ADDR_W   = 7;
  localparam int IMM_W    = 18;
  localparam int FMT_W    = 3;

  localparam logic [OP_W-1:0]  OP_NOP  = 11'h000;
  localparam logic [FMT_W-1:0] FMT_RR  = 3'd0;
  localparam logic [FMT_W-1:0] FMT_RI7 = 3'd2;

  localparam logic [OP_W-1:0] OP_SHLH    = 11'h05F;
  localparam logic [OP_W-1:0] OP_SHL     = 11'h05B;
  localparam logic [OP_W-1:0] OP_ROTH    = 11'h05C;
  localparam logic [OP_W-1:0] OP_ROT     = 11'h058;
  localparam logic [OP_W-1:0] OP_ROTHM   = 11'h05D;
  localparam logic [OP_W-1:0] OP_ROTM    = 11'h059;
  localparam logic [OP_W-1:0] OP_ROTMAH  = 11'h05E;
  localparam logic [OP_W-1:0] OP_ROTMA   = 11'h05A;
  localparam logic [OP_W-1:0] OP_SHLI    = 11'h07B;
  localparam logic [OP_W-1:0] OP_ROTHI   = 11'h07C;
  localparam logic [OP_W-1:0] OP_ROTI    = 11'h078;
  localparam logic [OP_W-1:0] OP_ROTMAHI = 11'h07E;
  localparam logic [OP_W-1:0] OP_ROTMAI  = 11'h07A;
endpackage

// File: rtl/spu_scoreboard.sv
// Per-register outstanding-write counters, RAW/saturation hazard detection and issue handshake.
module spu_scoreboard
  import spu_pkg::*;
#(
  parameter int NUM_REGS = spu_pkg::NUM_REGS,
  parameter int CNT_W    = spu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  input  logic              ra_used,
  input  logic              rb_used,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_reg_write,
  output logic              in_ready,
  output logic              fire
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_t;
  logic             hz_a, hz_b, sat;

  assign cnt_a = cnt[ra_addr];
  assign cnt_b = cnt[rb_addr];
  assign cnt_t = cnt[rt_addr];

  // A single outstanding write landing this cycle is covered by the bypass.
  assign hz_a = ra_used && (cnt_a != '0) &&
                !(cnt_a == CNT_ONE && wb_reg_write && wb_addr == ra_addr);
  assign hz_b = rb_used && (cnt_b != '0) &&
                !(cnt_b == CNT_ONE && wb_reg_write && wb_addr == rb_addr);
  assign sat  = reg_write && (cnt_t == CNT_MAX);

  assign in_ready = !(hz_a || hz_b || sat);
  assign fire     = in_valid && in_ready;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    logic [CNT_W-1:0] c;
    logic             inc, dec;
    assign inc    = fire && reg_write && (rt_addr == ADDR_W'(g));
    assign dec    = wb_reg_write && (wb_addr == ADDR_W'(g)) && (c != '0);
    assign cnt[g] = c;
    always_ff @(posedge clk) begin
      if (reset)            c <= '0;
      else if (inc && !dec) c <= c + CNT_ONE;
      else if (dec && !inc) c <= c - CNT_ONE;
    end
  end
endmodule

// File: rtl/spu_reg_fetch.sv
// SPU register fetch/issue: register file, writeback bypass and registered operand issue.
module spu_reg_fetch
  import spu_pkg::*;
#(
  parameter int NUM_REGS = spu_pkg::NUM_REGS,
  parameter int REG_W    = spu_pkg::REG_W,
  parameter int CNT_W    = spu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [FMT_W-1:0]  in_format,
  input  logic [ADDR_W-1:0] in_ra_addr,
  input  logic [ADDR_W-1:0] in_rb_addr,
  input  logic              in_ra_used,
  input  logic              in_rb_used,
  input  logic [ADDR_W-1:0] in_rt_addr,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_reg_write,
  input  logic [REG_W-1:0]  wb_rt,
  input  logic [ADDR_W-1:0] wb_rt_addr,
  input  logic              wb_reg_write,
  output logic [OP_W-1:0]   op,
  output logic [FMT_W-1:0]  format,
  output logic [ADDR_W-1:0] rt_addr,
  output logic [REG_W-1:0]  ra,
  output logic [REG_W-1:0]  rb,
  output logic [IMM_W-1:0]  imm,
  output logic              reg_write
);
  logic [REG_W-1:0] rf [NUM_REGS];
  logic [REG_W-1:0] ra_val, rb_val;
  logic             fire;

  spu_scoreboard #(.NUM_REGS(NUM_REGS), .CNT_W(CNT_W)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .ra_addr      (in_ra_addr),
    .rb_addr      (in_rb_addr),
    .ra_used      (in_ra_used),
    .rb_used      (in_rb_used),
    .rt_addr      (in_rt_addr),
    .reg_write    (in_reg_write),
    .wb_addr      (wb_rt_addr),
    .wb_reg_write (wb_reg_write),
    .in_ready     (in_ready),
    .fire         (fire)
  );

  assign ra_val = (wb_reg_write && wb_rt_addr == in_ra_addr) ? wb_rt : rf[in_ra_addr];
  assign rb_val = (wb_reg_write && wb_rt_addr == in_rb_addr) ? wb_rt : rf[in_rb_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (wb_reg_write) begin
      rf[wb_rt_addr] <= wb_rt;
    end
  end

  // Anything not issuing this cycle becomes an all-zero nop bubble.
  always_ff @(posedge clk) begin
    if (reset || !fire) begin
      op        <= OP_NOP;
      format    <= FMT_RR;
      rt_addr   <= '0;
      ra        <= '0;
      rb        <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
    end else begin
      op        <= in_op;
      format    <= in_format;
      rt_addr   <= in_rt_addr;
      ra        <= ra_val;
      rb        <= rb_val;
      imm       <= in_imm;
      reg_write <= in_reg_write;
    end
  end
endmodule

// File: tb/tb_spu_reg_fetch.sv
// Bench for spu_reg_fetch: register-file/scoreboard model checked every cycle plus directed literals.
module tb_spu_reg_fetch;
  import spu_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready;
  logic [OP_W-1:0]   in_op;
  logic [FMT_W-1:0]  in_format;
  logic [ADDR_W-1:0] in_ra_addr, in_rb_addr, in_rt_addr;
  logic              in_ra_used, in_rb_used, in_reg_write;
  logic [IMM_W-1:0]  in_imm;
  logic [REG_W-1:0]  wb_rt;
  logic [ADDR_W-1:0] wb_rt_addr;
  logic              wb_reg_write;
  logic [OP_W-1:0]   op;
  logic [FMT_W-1:0]  format;
  logic [ADDR_W-1:0] rt_addr;
  logic [REG_W-1:0]  ra, rb;
  logic [IMM_W-1:0]  imm;
  logic              reg_write;

  int nchk = 0;
  int nerr = 0;
  bit chk_en = 0;

  spu_reg_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_format(in_format), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
    .in_ra_used(in_ra_used), .in_rb_used(in_rb_used), .in_rt_addr(in_rt_addr),
    .in_imm(in_imm), .in_reg_write(in_reg_write), .wb_rt(wb_rt), .wb_rt_addr(wb_rt_addr),
    .wb_reg_write(wb_reg_write), .op(op), .format(format), .rt_addr(rt_addr),
    .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [127:0] m_rf [128];
  int           m_cnt [128];
  logic [10:0]  e_op;
  logic [2:0]   e_fmt;
  logic [6:0]   e_rt;
  logic [127:0] e_ra, e_rb;
  logic [17:0]  e_imm;
  logic         e_rw;

  function automatic bit m_wait(input int src, input bit used);
    if (!used || m_cnt[src] == 0) return 0;
    if (m_cnt[src] == 1 && wb_reg_write && int'(wb_rt_addr) == src) return 0;
    return 1;
  endfunction

  function automatic bit m_ready();
    if (m_wait(int'(in_ra_addr), in_ra_used)) return 0;
    if (m_wait(int'(in_rb_addr), in_rb_used)) return 0;
    if (in_reg_write && m_cnt[int'(in_rt_addr)] >= 7) return 0;
    return 1;
  endfunction

  function automatic logic [127:0] m_read(input int src);
    if (wb_reg_write && int'(wb_rt_addr) == src) return wb_rt;
    return m_rf[src];
  endfunction

  always @(posedge clk) begin
    bit fire, dec;
    if (reset) begin
      for (int i = 0; i < 128; i++) begin m_rf[i] = '0; m_cnt[i] = 0; end
      {e_op, e_fmt, e_rt, e_ra, e_rb, e_imm, e_rw} = '0;
    end else begin
      fire = in_valid && m_ready();
      if (fire) begin
        e_op = in_op; e_fmt = in_format; e_rt = in_rt_addr; e_imm = in_imm; e_rw = in_reg_write;
        e_ra = m_read(int'(in_ra_addr)); e_rb = m_read(int'(in_rb_addr));
      end else begin
        {e_op, e_fmt, e_rt, e_ra, e_rb, e_imm, e_rw} = '0;
      end
      dec = wb_reg_write && m_cnt[int'(wb_rt_addr)] > 0;
      if (fire && in_reg_write) m_cnt[int'(in_rt_addr)]++;
      if (dec) m_cnt[int'(wb_rt_addr)]--;
      if (wb_reg_write) m_rf[int'(wb_rt_addr)] = wb_rt;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 128'(in_ready), 128'(m_ready()));
      chk("op", 128'(op), 128'(e_op));
      chk("format", 128'(format), 128'(e_fmt));
      chk("rt_addr", 128'(rt_addr), 128'(e_rt));
      chk("ra", ra, e_ra);
      chk("rb", rb, e_rb);
      chk("imm", 128'(imm), 128'(e_imm));
      chk("reg_write", 128'(reg_write), 128'(e_rw));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [10:0] o, input int a, input bit au,
                       input int b, input bit bu, input int t, input bit w,
                       input bit we, input int wa, input logic [127:0] wd);
    in_valid = v; in_op = o; in_format = FMT_RR;
    in_ra_addr = 7'(a); in_ra_used = au; in_rb_addr = 7'(b); in_rb_used = bu;
    in_rt_addr = 7'(t); in_reg_write = w; in_imm = 18'(t * 3 + 1);
    wb_reg_write = we; wb_rt_addr = 7'(wa); wb_rt = wd;
  endtask

  task automatic idle();
    drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 0, 0, '0);
  endtask

  localparam logic [127:0] V3  = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] V10 = 128'hDEADBEEF_00000000_12345678_0000000A;
  localparam logic [127:0] VA  = 128'hAAAA_0001;
  localparam logic [127:0] VB  = 128'hBBBB_0002;
  localparam logic [127:0] VC  = 128'hCCCC_0003;
  localparam logic [127:0] VD  = 128'hDDDD_0004;

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_op", 128'(op), 128'd0);
    chk("rst_reg_write", 128'(reg_write), 128'd0);

    // reads of r5/r127 straight out of reset
    drive(1, OP_SHL, 5, 1, 127, 1, 0, 0, 0, 0, '0);
    tick();
    chk("r5_zero", ra, '0);
    chk("r127_zero", rb, '0);
    chk("rd_op", 128'(op), 128'(OP_SHL));

    // writeback with nothing pending, read next cycle
    drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1, 3, V3);
    tick();
    drive(1, OP_SHL, 3, 1, 0, 0, 4, 1, 0, 0, '0);
    tick();
    chk("wb_then_read_ra", ra, V3);
    chk("wb_then_read_rw", 128'(reg_write), 128'd1);
    chk("wb_then_read_rt", 128'(rt_addr), 128'd4);
    drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1, 4, 128'h44);
    tick();

    // RAW stall resolved by bypass on the writeback cycle
    drive(1, OP_SHL, 1, 1, 0, 0, 10, 1, 0, 0, '0);
    tick();
    drive(1, OP_ROT, 10, 1, 0, 0, 11, 0, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      #1 chk("raw_stall_ready", 128'(in_ready), 128'd0);
      tick();
      chk("raw_bubble_op", 128'(op), 128'd0);
    end
    drive(1, OP_ROT, 10, 1, 0, 0, 11, 0, 1, 10, V10);
    #1 chk("raw_wb_ready", 128'(in_ready), 128'd1);
    tick();
    chk("raw_issue_op", 128'(op), 128'(OP_ROT));
    chk("raw_bypass_ra", ra, V10);
    drive(1, OP_ROT, 10, 1, 0, 0, 11, 0, 0, 0, '0);
    #1 chk("raw_cnt_clear", 128'(in_ready), 128'd1);
    tick();

    // WAW: reader waits for the second writeback
    drive(1, OP_SHLI, 0, 0, 0, 0, 20, 1, 0, 0, '0);
    tick(); tick();
    drive(1, OP_ROTM, 20, 1, 0, 0, 21, 0, 0, 0, '0);
    #1 chk("waw_stall", 128'(in_ready), 128'd0);
    tick();
    drive(1, OP_ROTM, 20, 1, 0, 0, 21, 0, 1, 20, VA);
    #1 chk("waw_first_wb_stall", 128'(in_ready), 128'd0);
    tick();
    drive(1, OP_ROTM, 20, 1, 0, 0, 21, 0, 1, 20, VB);
    #1 chk("waw_second_wb_ready", 128'(in_ready), 128'd1);
    tick();
    chk("waw_ra", ra, VB);

    // simultaneous inc/dec on r7 keeps the count at 1
    drive(1, OP_ROTI, 0, 0, 0, 0, 7, 1, 0, 0, '0);
    tick();
    drive(1, OP_ROTI, 0, 0, 0, 0, 7, 1, 1, 7, VC);
    tick();
    drive(1, OP_ROTH, 7, 1, 0, 0, 8, 0, 0, 0, '0);
    #1 chk("incdec_stall", 128'(in_ready), 128'd0);
    tick();
    chk("incdec_bubble", 128'(op), 128'd0);
    drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1, 7, VC);
    tick();

    // reset mid-flight drops pending writes on r9
    drive(1, OP_ROTMAI, 0, 0, 0, 0, 9, 1, 0, 0, '0);
    tick(); tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, OP_ROTMA, 9, 1, 0, 0, 12, 0, 0, 0, '0);
    #1 chk("post_rst_ready", 128'(in_ready), 128'd1);
    tick();
    chk("post_rst_ra", ra, '0);
    drive(0, OP_NOP, 0, 0, 0, 0, 0, 0, 1, 9, VD);
    tick();
    drive(1, OP_ROTMA, 9, 1, 0, 0, 12, 0, 0, 0, '0);
    #1 chk("late_wb_no_cnt", 128'(in_ready), 128'd1);
    tick();
    chk("late_wb_rf", ra, VD);

    // counter saturation on r30
    for (int i = 0; i < 7; i++) begin
      drive(1, OP_SHLI, 0, 0, 0, 0, 30, 1, 0, 0, '0);
      tick();
    end
    drive(1, OP_SHLI, 0, 0, 0, 0, 30, 1, 0, 0, '0);
    #1 chk("sat_stall", 128'(in_ready), 128'd0);
    tick();
    chk("sat_bubble", 128'(reg_write), 128'd0);

    // source equals destination with nothing pending
    drive(1, OP_SHLH, 9, 1, 9, 1, 9, 1, 0, 0, '0);
    #1 chk("src_eq_dst_ready", 128'(in_ready), 128'd1);
    tick();
    chk("src_eq_dst_ra", ra, VD);
    idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
